// File: rtl/cpu_clk_ctrl.sv
// Turns the divider's slow square wave into single-cycle core enables, with
// free-run, debounced single-step and core-requested halt modes.
module cpu_clk_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = $clog2(DEBOUNCE_CYCLES),
  parameter int TICK_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_clk,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic              halt_req,
  output logic              cpu_en,
  output logic              halted,
  output logic [TICK_W-1:0] tick_cnt
);

  typedef enum logic [1:0] {ST_STEP, ST_RUN, ST_HALT} state_t;

  state_t          state;
  logic            armed;
  logic            div_p0, div_s, div_prev;
  logic            btn_p0, btn_s;
  logic            stable_btn, stable_prev;
  logic [DB_W-1:0] db_cnt;
  logic            div_rise;
  logic            step_pulse;

  assign div_rise   = div_s & ~div_prev;
  assign step_pulse = stable_btn & ~stable_prev;

  // Synchronizers: div_clk and step_btn are asynchronous levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_p0   <= 1'b0;
      div_s    <= 1'b0;
      div_prev <= 1'b0;
      btn_p0   <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      div_p0   <= div_clk;
      div_s    <= div_p0;
      div_prev <= div_s;
      btn_p0   <= step_btn;
      btn_s    <= btn_p0;
    end
  end

  // Debounce: a new button level is accepted only after it holds for DEBOUNCE_CYCLES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt      <= '0;
      stable_btn  <= 1'b0;
      stable_prev <= 1'b0;
    end else begin
      stable_prev <= stable_btn;
      if (btn_s == stable_btn) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_btn <= btn_s;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Mode FSM with registered enable, halt flag and enable counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_STEP;
      armed    <= 1'b0;
      cpu_en   <= 1'b0;
      halted   <= 1'b0;
      tick_cnt <= '0;
    end else begin
      cpu_en <= 1'b0;
      case (state)
        ST_RUN: begin
          if (halt_req) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (!run_sw) begin
            state <= ST_STEP;
            armed <= 1'b0;
          end else if (div_rise) begin
            cpu_en   <= 1'b1;
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        ST_STEP: begin
          if (halt_req) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            armed  <= 1'b0;
          end else if (run_sw) begin
            state <= ST_RUN;
          end else if (armed && div_rise) begin
            // a step press landing on the same cycle is intentionally lost
            cpu_en   <= 1'b1;
            armed    <= 1'b0;
            tick_cnt <= tick_cnt + TICK_W'(1);
          end else if (step_pulse) begin
            armed <= 1'b1;
          end
        end
        ST_HALT: begin
          if (step_pulse && !run_sw) begin
            state  <= ST_STEP;
            halted <= 1'b0;
            armed  <= 1'b0;
          end
        end
        default: begin
          state  <= ST_STEP;
          halted <= 1'b0;
          armed  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model built from sample histories and run lengths.
module tb_cpu_clk_ctrl;
  localparam int DEB = 4;
  localparam int TW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          div_clk = 1'b0;
  logic          run_sw = 1'b0;
  logic          step_btn = 1'b0;
  logic          halt_req = 1'b0;
  logic          cpu_en;
  logic          halted;
  logic [TW-1:0] tick_cnt;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  always #10 clk = ~clk;

  cpu_clk_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_W(TW)) dut (
    .clk(clk), .rst(rst), .div_clk(div_clk), .run_sw(run_sw),
    .step_btn(step_btn), .halt_req(halt_req),
    .cpu_en(cpu_en), .halted(halted), .tick_cnt(tick_cnt)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=step 1=run 2=halt
  bit dq[$];
  bit bq[$];
  int mode;
  bit m_armed, m_stable, m_step_next, rise, step, bs;
  int m_run;
  bit exp_en, exp_halted;
  int exp_tick;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dq.delete(); bq.delete();
      repeat (3) begin dq.push_back(1'b0); bq.push_back(1'b0); end
      mode = 0; m_armed = 0; m_stable = 0; m_step_next = 0; m_run = 0;
      exp_en = 0; exp_halted = 0; exp_tick = 0;
    end else begin
      // an input level reaches the decision logic two edges after it is sampled
      rise = dq[1] && !dq[0];
      bs   = bq[1];
      step = m_step_next;
      exp_en = 0;
      case (mode)
        1: if (halt_req) mode = 2;
           else if (!run_sw) begin mode = 0; m_armed = 0; end
           else if (rise) begin exp_en = 1; exp_tick = (exp_tick + 1) % (1 << TW); end
        0: if (halt_req) begin mode = 2; m_armed = 0; end
           else if (run_sw) mode = 1;
           else if (m_armed && rise) begin
             exp_en = 1; m_armed = 0; exp_tick = (exp_tick + 1) % (1 << TW);
           end else if (step) m_armed = 1;
        default: if (step && !run_sw) begin mode = 0; m_armed = 0; end
      endcase
      exp_halted = (mode == 2);
      m_step_next = 0;
      if (bs != m_stable) begin
        m_run++;
        if (m_run == DEB) begin
          m_stable = bs; m_run = 0; m_step_next = bs;
        end
      end else begin
        m_run = 0;
      end
      dq.push_back(div_clk); void'(dq.pop_front());
      bq.push_back(step_btn); void'(bq.pop_front());
    end
  end

  bit prev_en = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_en = 0;
    end else begin
      check("cpu_en", cpu_en, exp_en);
      check("halted", halted, exp_halted);
      check("tick_cnt", tick_cnt, exp_tick);
      check("back_to_back", prev_en && cpu_en, 0);
      prev_en = cpu_en;
    end
  end

  always @(posedge clk) if (!rst && cpu_en === 1'b1) pulses++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic div_periods(input int n, input int half);
    repeat (n) begin
      div_clk = 1'b1; cyc(half);
      div_clk = 1'b0; cyc(half);
    end
  endtask

  task automatic press(input int hold);
    step_btn = 1'b1; cyc(hold);
    step_btn = 1'b0; cyc(hold);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; div_clk = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
    cyc(2);
    pulses = 0;
    rst = 1'b0;
  endtask

  initial begin
    int div_left, btn_left;
    cyc(3);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_halted", halted, 0);
    check("rst_tick", tick_cnt, 0);
    pulses = 0;
    rst = 1'b0;

    // free-run: 3-edge latency and one pulse per period
    run_sw = 1'b1; cyc(4);
    div_clk = 1'b1; cyc(2);
    check("lat_early", cpu_en, 0);
    cyc(1);
    check("lat_hit", cpu_en, 1);
    cyc(1);
    check("lat_after", cpu_en, 0);
    div_clk = 1'b0; cyc(4);
    div_periods(9, 4); cyc(6);
    check("t1_tick", tick_cnt, 10);
    check("t1_pulses", pulses, 10);

    // glitches are filtered, a held press steps once
    do_reset(); run_sw = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step_btn = 1'b1; cyc(k);
      step_btn = 1'b0; cyc(6);
    end
    div_periods(3, 4); cyc(4);
    check("t2_glitch_pulses", pulses, 0);
    press(10);
    div_periods(3, 4); cyc(4);
    check("t2_step_pulses", pulses, 1);
    check("t2_tick", tick_cnt, 1);

    // two presses before one rise give one enable
    do_reset(); run_sw = 1'b0;
    press(10); press(10);
    div_periods(3, 4); cyc(4);
    check("t3_pulses", pulses, 1);

    // halt coinciding with div_rise
    do_reset(); run_sw = 1'b1; cyc(4);
    div_periods(2, 4);
    div_clk = 1'b1; cyc(2);
    halt_req = 1'b1; cyc(1);
    halt_req = 1'b0;
    check("t4_en_suppressed", cpu_en, 0);
    check("t4_halted", halted, 1);
    cyc(3); div_clk = 1'b0; cyc(4);
    div_periods(3, 4);
    run_sw = 1'b0; cyc(3); run_sw = 1'b1; cyc(3);
    check("t4_still_halted", halted, 1);
    run_sw = 1'b0; cyc(2);
    check("t4_halt_pulses", pulses, 2);
    press(10);
    check("t4_left_halt", halted, 0);
    div_periods(3, 4); cyc(4);
    check("t4_no_step", pulses, 2);
    press(10);
    div_periods(2, 4); cyc(4);
    check("t4_step", pulses, 3);

    // counter wrap
    do_reset(); run_sw = 1'b1; cyc(4);
    div_periods(17, 2); cyc(6);
    check("t5_wrap_tick", tick_cnt, 1);
    check("t5_pulses", pulses, 17);

    // asynchronous reset while cpu_en is high
    do_reset(); run_sw = 1'b1; cyc(4);
    div_periods(2, 4);
    div_clk = 1'b1; cyc(3);
    check("t6_pre_en", cpu_en, 1);
    #3 rst = 1'b1;
    #2;
    check("t6_async_en", cpu_en, 0);
    check("t6_async_halted", halted, 0);
    check("t6_async_tick", tick_cnt, 0);
    run_sw = 1'b0;
    #2 rst = 1'b0;
    pulses = 0;
    cyc(1); div_clk = 1'b0; cyc(4);
    div_periods(3, 4); cyc(4);
    check("t6_step_idle", pulses, 0);
    run_sw = 1'b1; cyc(2);
    div_periods(2, 4); cyc(4);
    check("t6_run_resume", pulses, 2);

    // randomized traffic
    do_reset();
    div_left = 3; btn_left = 5;
    for (int i = 0; i < 4000; i++) begin
      div_left--;
      if (div_left <= 0) begin
        div_clk = ~div_clk;
        div_left = $urandom_range(1, 6);
      end
      btn_left--;
      if (btn_left <= 0) begin
        step_btn = ~step_btn;
        btn_left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12);
      end
      halt_req = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0) run_sw = ~run_sw;
      cyc(1);
    end
    halt_req = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
